// File: rtl/protocol_frame_parser_pkg.sv
// Shared definitions for the host frame parser: sync byte defaults, command
// codes, FSM state encoding and the running checksum helper.
package protocol_frame_parser_pkg;

  // Default sync bytes that open every host frame
  localparam logic [7:0] HEADER0_DEFAULT = 8'hAA;
  localparam logic [7:0] HEADER1_DEFAULT = 8'h55;

  // Command codes understood by the downstream command processor
  localparam logic [7:0] CMD_RESET = 8'h20;

  // Frame parser FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR1    = 3'd1,
    CMD     = 3'd2,
    LEN_H   = 3'd3,
    LEN_L   = 3'd4,
    PAYLOAD = 3'd5,
    CHECK   = 3'd6
  } state_t;

  // Modulo-256 running checksum step
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/protocol_frame_parser_if.sv
// Host-side bus of the frame parser: RX byte stream in, frame status out,
// and the payload read port used by the command processor.
interface protocol_frame_parser_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              parse_done;
  logic              parse_error;
  logic [7:0]        cmd_out;
  logic [15:0]       len_out;
  logic [ADDR_W-1:0] payload_read_addr;
  logic [7:0]        payload_read_data;

  // Host / consumer side
  modport master (
    output rx_data, rx_valid, payload_read_addr,
    input  parse_done, parse_error, cmd_out, len_out, payload_read_data
  );

  // Parser side
  modport slave (
    input  rx_data, rx_valid, payload_read_addr,
    output parse_done, parse_error, cmd_out, len_out, payload_read_data
  );
endinterface

// File: rtl/protocol_frame_parser_buffer.sv
// Payload buffer: simple dual-port RAM, 2**ADDR_W x 8, synchronous write and
// registered read. A read of the address being written returns the old data.
module protocol_frame_parser_buffer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [0:(1<<ADDR_W)-1];
  logic [7:0] rdata_r;

  // Write port: contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/protocol_frame_parser.sv
// Host frame parser: frames HEADER0 HEADER1 CMD LEN_H LEN_L PAYLOAD[LEN] CHK,
// stores the payload, and reports accepted / dropped frames with 1-cycle pulses.
// Optional inter-byte timeout is enabled by defining PARSER_TIMEOUT_EN.
module protocol_frame_parser
  import protocol_frame_parser_pkg::*;
#(
  parameter int         PAYLOAD_ADDR_WIDTH = 10,
  parameter logic [7:0] HEADER0            = HEADER0_DEFAULT,
  parameter logic [7:0] HEADER1            = HEADER1_DEFAULT,
  parameter int         TIMEOUT_CYCLES     = 60000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  protocol_frame_parser_if.slave   bus
);

  // Largest legal LEN; one more than the top buffer address
  localparam logic [16:0] MAX_LEN = 17'd1 << PAYLOAD_ADDR_WIDTH;

  state_t      state_r, state_next;
  logic [7:0]  cmd_r, cmd_next;
  logic [15:0] len_r, len_next;
  logic [7:0]  chk_r, chk_next;
  logic [15:0] cnt_r, cnt_next;
  logic [15:0] len_full_s;
  logic        we_s;
  logic        done_s;
  logic        error_s;
  logic        timeout_s;
  logic        parse_done_r;
  logic        parse_error_r;
  logic [7:0]  cmd_out_r;
  logic [15:0] len_out_r;

  assign len_full_s = {len_r[15:8], bus.rx_data};

`ifdef PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Idle-cycle counter: runs only while a frame is in progress and no byte arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == IDLE || bus.rx_valid || timeout_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  assign timeout_s = (state_r != IDLE) && !bus.rx_valid &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and datapath control; the FSM only moves on an accepted byte or timeout
  always_comb begin
    state_next = state_r;
    cmd_next   = cmd_r;
    len_next   = len_r;
    chk_next   = chk_r;
    cnt_next   = cnt_r;
    we_s       = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    if (timeout_s) begin
      state_next = IDLE;
      error_s    = 1'b1;
    end else if (bus.rx_valid) begin
      case (state_r)
        IDLE: begin
          if (bus.rx_data == HEADER0) begin
            state_next = HDR1;
          end else begin
            state_next = IDLE;
          end
        end
        HDR1: begin
          if (bus.rx_data == HEADER1) begin
            state_next = CMD;
          end else if (bus.rx_data == HEADER0) begin
            state_next = HDR1;
          end else begin
            state_next = IDLE;
          end
        end
        CMD: begin
          cmd_next   = bus.rx_data;
          chk_next   = bus.rx_data;
          state_next = LEN_H;
        end
        LEN_H: begin
          len_next   = {bus.rx_data, len_r[7:0]};
          chk_next   = chk_add(chk_r, bus.rx_data);
          state_next = LEN_L;
        end
        LEN_L: begin
          len_next = len_full_s;
          chk_next = chk_add(chk_r, bus.rx_data);
          if ({1'b0, len_full_s} > MAX_LEN) begin
            error_s    = 1'b1;
            state_next = IDLE;
          end else if (len_full_s == 16'd0) begin
            state_next = CHECK;
          end else begin
            cnt_next   = 16'd0;
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          we_s     = 1'b1;
          chk_next = chk_add(chk_r, bus.rx_data);
          if (cnt_r == len_r - 16'd1) begin
            state_next = CHECK;
          end else begin
            cnt_next   = cnt_r + 16'd1;
            state_next = PAYLOAD;
          end
        end
        CHECK: begin
          if (bus.rx_data == chk_r) begin
            done_s = 1'b1;
          end else begin
            error_s = 1'b1;
          end
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else begin
      state_next = state_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Frame fields, checksum, write pointer and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r         <= 8'h00;
      len_r         <= 16'h0000;
      chk_r         <= 8'h00;
      cnt_r         <= 16'h0000;
      parse_done_r  <= 1'b0;
      parse_error_r <= 1'b0;
      cmd_out_r     <= 8'h00;
      len_out_r     <= 16'h0000;
    end else begin
      cmd_r         <= cmd_next;
      len_r         <= len_next;
      chk_r         <= chk_next;
      cnt_r         <= cnt_next;
      parse_done_r  <= done_s;
      parse_error_r <= error_s;
      if (done_s) begin
        cmd_out_r <= cmd_r;
        len_out_r <= len_r;
      end
    end
  end

  assign bus.parse_done  = parse_done_r;
  assign bus.parse_error = parse_error_r;
  assign bus.cmd_out     = cmd_out_r;
  assign bus.len_out     = len_out_r;

  protocol_frame_parser_buffer #(
    .ADDR_W (PAYLOAD_ADDR_WIDTH)
  ) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (cnt_r[PAYLOAD_ADDR_WIDTH-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.payload_read_addr),
    .rdata (bus.payload_read_data)
  );

endmodule

// File: tb/tb_protocol_frame_parser.sv
// Self-checking bench for protocol_frame_parser: directed frames from the
// block's test list plus randomized frames checked against a frame-level model.
module tb_protocol_frame_parser;
  import protocol_frame_parser_pkg::*;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  protocol_frame_parser_if #(.ADDR_W(W)) bus();

  protocol_frame_parser #(
    .PAYLOAD_ADDR_WIDTH (W),
    .HEADER0            (8'hAA),
    .HEADER1            (8'h55),
    .TIMEOUT_CYCLES     (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [7:0]  exp_cmd = 8'h00;
  logic [15:0] exp_len = 16'h0000;
  logic [7:0]  pay [$];

  // Pulse monitor
  always @(negedge clk) begin
    if (bus.parse_done === 1'b1) done_cnt++;
    if (bus.parse_error === 1'b1) err_cnt++;
    if (bus.parse_done === 1'b1 && bus.parse_error === 1'b1) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  // Sends a frame carrying the payload in pay[]; checksum from the frame rules
  task automatic send_frame(input logic [7:0] cmd, input bit corrupt, input bit gaps);
    logic [15:0] l16;
    logic [7:0]  chk;
    l16 = 16'(pay.size());
    chk = cmd + l16[15:8] + l16[7:0];
    send_byte(8'hAA); maybe_gap(gaps);
    send_byte(8'h55); maybe_gap(gaps);
    send_byte(cmd);   maybe_gap(gaps);
    send_byte(l16[15:8]); maybe_gap(gaps);
    send_byte(l16[7:0]);  maybe_gap(gaps);
    foreach (pay[i]) begin
      send_byte(pay[i]);
      chk = chk + pay[i];
      maybe_gap(gaps);
    end
    if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
    send_byte(chk);
  endtask

  task automatic test_reset;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.payload_read_addr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (bus.parse_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", bus.parse_done); end
    compared++; if (bus.parse_error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b expected 0", bus.parse_error); end
    compared++; if (bus.cmd_out !== 8'h00) begin mismatched++; $display("FAIL reset_cmd: got %h expected 00", bus.cmd_out); end
    compared++; if (bus.len_out !== 16'h0000) begin mismatched++; $display("FAIL reset_len: got %h expected 0000", bus.len_out); end
    compared++; if (bus.payload_read_data !== 8'h00) begin mismatched++; $display("FAIL reset_rdata: got %h expected 00", bus.payload_read_data); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_zero_len;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pay.delete();
    send_frame(CMD_RESET, 1'b0, 1'b0);
    idle(3);
    exp_cmd = CMD_RESET; exp_len = 16'd0;
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL zero_len_done: got %0d expected 1", done_cnt - d0); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL zero_len_err: got %0d expected 0", err_cnt - e0); end
    compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL zero_len_cmd: got %h expected %h", bus.cmd_out, exp_cmd); end
    compared++; if (bus.len_out !== exp_len) begin mismatched++; $display("FAIL zero_len_len: got %h expected %h", bus.len_out, exp_len); end
  endtask

  task automatic test_payload_read;
    int d0;
    d0 = done_cnt;
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h01, 1'b0, 1'b0);
    // Timing check: pulse visible on the cycle right after CHK
    @(negedge clk); bus.rx_valid = 1'b0;
    compared++; if (bus.parse_done !== 1'b1) begin mismatched++; $display("FAIL payload_done_timing: got %b expected 1", bus.parse_done); end
    idle(2);
    exp_cmd = 8'h01; exp_len = 16'd3;
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL payload_done: got %0d expected 1", done_cnt - d0); end
    compared++; if (bus.len_out !== exp_len) begin mismatched++; $display("FAIL payload_len: got %h expected %h", bus.len_out, exp_len); end
    for (int a = 0; a < 3; a++) begin
      bus.payload_read_addr = W'(a);
      @(negedge clk);
      compared++; if (bus.payload_read_data !== pay[a]) begin mismatched++; $display("FAIL payload_read[%0d]: got %h expected %h", a, bus.payload_read_data, pay[a]); end
    end
  endtask

  task automatic test_bad_checksum;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pay = '{8'h11, 8'h22, 8'h33};
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h6B);
    idle(3);
    compared++; if (err_cnt - e0 !== 1) begin mismatched++; $display("FAIL badchk_err: got %0d expected 1", err_cnt - e0); end
    compared++; if (done_cnt - d0 !== 0) begin mismatched++; $display("FAIL badchk_done: got %0d expected 0", done_cnt - d0); end
    compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL badchk_cmd: got %h expected %h", bus.cmd_out, exp_cmd); end
    compared++; if (bus.len_out !== exp_len) begin mismatched++; $display("FAIL badchk_len: got %h expected %h", bus.len_out, exp_len); end
  endtask

  task automatic test_resync;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    idle(3);
    exp_cmd = 8'h20; exp_len = 16'd0;
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL resync_done: got %0d expected 1", done_cnt - d0); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL resync_err: got %0d expected 0", err_cnt - e0); end
    compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL resync_cmd: got %h expected %h", bus.cmd_out, exp_cmd); end
  endtask

  task automatic test_oversize;
    int d0;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h05); send_byte(8'h04); send_byte(8'h01);
    @(negedge clk); bus.rx_valid = 1'b0;
    compared++; if (bus.parse_error !== 1'b1) begin mismatched++; $display("FAIL oversize_err_timing: got %b expected 1", bus.parse_error); end
    compared++; if (bus.parse_done !== 1'b0) begin mismatched++; $display("FAIL oversize_done: got %b expected 0", bus.parse_done); end
    idle(2);
    d0 = done_cnt;
    pay.delete();
    send_frame(8'h20, 1'b0, 1'b0);
    idle(3);
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL oversize_recover: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_max_len;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pay.delete();
    for (int i = 0; i < (1 << W); i++) pay.push_back(8'($urandom));
    send_frame(8'h42, 1'b0, 1'b0);
    idle(3);
    exp_cmd = 8'h42; exp_len = 16'(1 << W);
    compared++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin mismatched++; $display("FAIL maxlen_status: got done %0d err %0d expected 1 0", done_cnt - d0, err_cnt - e0); end
    compared++; if (bus.len_out !== exp_len) begin mismatched++; $display("FAIL maxlen_len: got %h expected %h", bus.len_out, exp_len); end
    for (int k = 0; k < 4; k++) begin
      int a;
      a = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 511 : (1 << W) - 1;
      bus.payload_read_addr = W'(a);
      @(negedge clk);
      compared++; if (bus.payload_read_data !== pay[a]) begin mismatched++; $display("FAIL maxlen_read[%0d]: got %h expected %h", a, bus.payload_read_data, pay[a]); end
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 25; f++) begin
      int d0, e0, len;
      bit bad;
      logic [7:0] cmd;
      d0 = done_cnt; e0 = err_cnt;
      len = (f == 0) ? 1 : $urandom_range(0, 48);
      bad = ($urandom_range(0, 3) == 0);
      cmd = 8'($urandom);
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 169)));
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      send_frame(cmd, bad, 1'b1);
      idle(3);
      if (!bad) begin exp_cmd = cmd; exp_len = 16'(len); end
      compared++; if (done_cnt - d0 !== (bad ? 0 : 1)) begin mismatched++; $display("FAIL rand%0d_done: got %0d expected %0d", f, done_cnt - d0, bad ? 0 : 1); end
      compared++; if (err_cnt - e0 !== (bad ? 1 : 0)) begin mismatched++; $display("FAIL rand%0d_err: got %0d expected %0d", f, err_cnt - e0, bad ? 1 : 0); end
      compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL rand%0d_cmd: got %h expected %h", f, bus.cmd_out, exp_cmd); end
      compared++; if (bus.len_out !== exp_len) begin mismatched++; $display("FAIL rand%0d_len: got %h expected %h", f, bus.len_out, exp_len); end
      if (!bad) begin
        for (int a = 0; a < len; a++) begin
          bus.payload_read_addr = W'(a);
          @(negedge clk);
          compared++; if (bus.payload_read_data !== pay[a]) begin mismatched++; $display("FAIL rand%0d_read[%0d]: got %h expected %h", f, a, bus.payload_read_data, pay[a]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pay = '{8'hAA, 8'h55};
    send_frame(8'h07, 1'b0, 1'b0);
    pay = '{8'h01};
    send_frame(8'h09, 1'b0, 1'b0);
    idle(3);
    exp_cmd = 8'h09; exp_len = 16'd1;
    compared++; if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin mismatched++; $display("FAIL b2b_status: got done %0d err %0d expected 2 0", done_cnt - d0, err_cnt - e0); end
    compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL b2b_cmd: got %h expected %h", bus.cmd_out, exp_cmd); end
  endtask

`ifdef PARSER_TIMEOUT_EN
  task automatic test_timeout;
    int d0, e0;
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03); send_byte(8'h11);
    idle(99);
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL timeout_early: got %0d expected 0", err_cnt - e0); end
    idle(3);
    compared++; if (err_cnt - e0 !== 1) begin mismatched++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
    d0 = done_cnt;
    pay.delete();
    send_frame(8'h20, 1'b0, 1'b0);
    idle(3);
    exp_cmd = 8'h20; exp_len = 16'd0;
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL timeout_recover: got %0d expected 1", done_cnt - d0); end
  endtask
`endif

  task automatic test_mid_reset;
    int d0;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk); bus.rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_cmd = 8'h00; exp_len = 16'd0;
    compared++; if (bus.cmd_out !== 8'h00 || bus.len_out !== 16'h0000) begin mismatched++; $display("FAIL midrst_fields: got %h/%h expected 00/0000", bus.cmd_out, bus.len_out); end
    compared++; if (bus.parse_done !== 1'b0 || bus.parse_error !== 1'b0 || bus.payload_read_data !== 8'h00) begin mismatched++; $display("FAIL midrst_outs: got %b%b %h expected 00 00", bus.parse_done, bus.parse_error, bus.payload_read_data); end
    @(negedge clk); rst_n = 1'b1;
    d0 = done_cnt;
    pay.delete();
    send_frame(8'h20, 1'b0, 1'b0);
    idle(3);
    exp_cmd = 8'h20;
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL midrst_recover_done: got %0d expected 1", done_cnt - d0); end
    compared++; if (bus.cmd_out !== exp_cmd) begin mismatched++; $display("FAIL midrst_recover_cmd: got %h expected %h", bus.cmd_out, exp_cmd); end
  endtask

  task automatic test_exclusive;
    compared++; if (both_cnt !== 0) begin mismatched++; $display("FAIL done_error_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_payload_read();
    test_bad_checksum();
    test_resync();
    test_oversize();
    test_max_len();
    test_random();
    test_back_to_back();
`ifdef PARSER_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_reset();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
